// File: rtl/dmem_pkg.sv
// Shared constants, FSM encoding and address check for the data-memory arbiter.
package dmem_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NREQ       = 2;

    localparam logic [31:0] DMEM_BASE  = 32'h0000_2000;
    localparam int unsigned DMEM_DEPTH = 512;

    localparam int unsigned REQ_CPU    = 0;
    localparam int unsigned REQ_DBG    = 1;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_RESP   = 2'd2;

    // Word-aligned and inside [base, base + 4*depth); 33-bit so the top bound never wraps.
    function automatic logic addr_legal(input logic [31:0] a,
                                        input logic [31:0] base,
                                        input int unsigned depth);
        logic [32:0] w_av;
        logic [32:0] w_lo;
        logic [32:0] w_hi;
        w_av = {1'b0, a};
        w_lo = {1'b0, base};
        w_hi = w_lo + (33'(depth) << 2);
        return (a[1:0] == 2'b00) && (w_av >= w_lo) && (w_av < w_hi);
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way picker: fixed priority to requester 0 or round-robin via a one-bit pointer.
module dmem_rr_pick #(
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_gnt,
    output logic       o_ptr_nxt
);

    // One-hot winner; the pointer moves to whoever lost.
    always_comb begin
        o_gnt     = 2'b00;
        o_ptr_nxt = i_ptr;
        if (i_req == 2'b11) begin
            if (FIXED_PRI || !i_ptr) o_gnt = 2'b01;
            else                     o_gnt = 2'b10;
        end else begin
            o_gnt = i_req;
        end
        if (o_gnt[0])      o_ptr_nxt = 1'b1;
        else if (o_gnt[1]) o_ptr_nxt = 1'b0;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU (req 0) and debug port (req 1).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DMEM_BASE,
    parameter int unsigned DEPTH     = DMEM_DEPTH,
    parameter bit          FIXED_PRI = 1'b0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_MemWrite,
    output logic              mem_MemRead,
    output logic [ADDR_W-1:0] mem_Addr,
    output logic [DATA_W-1:0] mem_Wdata,
    input  logic [DATA_W-1:0] mem_Rdata
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_take;

    logic                r_ptr;
    logic                w_ptr_nxt;
    logic [1:0]          w_pick;

    logic                r_owner;
    logic                r_we;
    logic                r_err;

    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_mem_write;
    logic                r_mem_read;
    logic [NREQ-1:0]     r_rsp_valid;
    logic                r_rsp_err;
    logic [DATA_W-1:0]   r_rsp_rdata;

    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_legal;

    dmem_rr_pick #(
        .FIXED_PRI (FIXED_PRI)
    ) u_pick (
        .i_req     (req),
        .i_ptr     (r_ptr),
        .o_gnt     (w_pick),
        .o_ptr_nxt (w_ptr_nxt)
    );

    // Fields of the winning requester and their legality.
    always_comb begin
        w_sel_we    = w_pick[1] ? we[1]  : we[0];
        w_sel_addr  = w_pick[1] ? addr1  : addr0;
        w_sel_wdata = w_pick[1] ? wdata1 : wdata0;
        w_legal     = addr_legal(w_sel_addr, BASE_ADDR, DEPTH);
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state; w_take marks the accepting IDLE cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant is combinational in the accepting cycle and forced low while in reset.
    assign gnt = (w_take && reset_n) ? w_pick : 2'b00;

    // Latch the request, drive strobes for one ACCESS cycle, then one response cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr       <= 1'b0;
            r_owner     <= 1'b0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            if (w_take) begin
                r_ptr   <= w_ptr_nxt;
                r_owner <= w_pick[1];
                r_we    <= w_sel_we;
                r_err   <= !w_legal;
                if (w_legal) begin
                    r_mem_addr  <= w_sel_addr;
                    r_mem_wdata <= w_sel_wdata;
                    r_mem_write <= w_sel_we;
                    r_mem_read  <= !w_sel_we;
                end
            end
            if (r_state == ST_ACCESS) begin
                r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
                r_rsp_err   <= r_err;
                if (!r_err && !r_we) r_rsp_rdata <= mem_Rdata;
            end
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_err      = r_rsp_err;
    assign rsp_rdata    = r_rsp_rdata;
    assign mem_MemWrite = r_mem_write;
    assign mem_MemRead  = r_mem_read;
    assign mem_Addr     = r_mem_addr;
    assign mem_Wdata    = r_mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 512-word data memory.
module tb_dmem_arbiter;

    logic        clock;
    logic        reset_n;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]  gnt, rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_MemWrite, mem_MemRead;
    logic [31:0] mem_Addr, mem_Wdata, mem_Rdata;

    logic [1:0]  fp_gnt, fp_rsp_valid;
    logic        fp_rsp_err, fp_mem_MemWrite, fp_mem_MemRead;
    logic [31:0] fp_rsp_rdata, fp_mem_Addr, fp_mem_Wdata;

    logic [31:0] tb_mem [0:511];
    logic [8:0]  w_idx;

    int checks = 0;
    int errors = 0;

    dmem_arbiter u_dut (
        .clock(clock), .reset_n(reset_n), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead),
        .mem_Addr(mem_Addr), .mem_Wdata(mem_Wdata), .mem_Rdata(mem_Rdata)
    );

    dmem_arbiter #(.FIXED_PRI(1'b1)) u_dut_fp (
        .clock(clock), .reset_n(reset_n), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt(fp_gnt), .rsp_valid(fp_rsp_valid), .rsp_err(fp_rsp_err), .rsp_rdata(fp_rsp_rdata),
        .mem_MemWrite(fp_mem_MemWrite), .mem_MemRead(fp_mem_MemRead),
        .mem_Addr(fp_mem_Addr), .mem_Wdata(fp_mem_Wdata), .mem_Rdata(32'h0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural memory: combinational read, write on the rising edge.
    assign w_idx     = 9'((mem_Addr - 32'h0000_2000) >> 2);
    assign mem_Rdata = tb_mem[w_idx];
    always @(posedge clock) begin
        if (mem_MemWrite) tb_mem[w_idx] <= mem_Wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Full single-requester transaction starting in IDLE, checked cycle by cycle.
    task automatic txn(input int r, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic exp_err, input logic [31:0] exp_rd, input string tag);
        logic [1:0] oh;
        oh = (r == 0) ? 2'b01 : 2'b10;
        if (r == 0) begin addr0 = a; wdata0 = d; end
        else        begin addr1 = a; wdata1 = d; end
        we[r]  = w;
        req[r] = 1'b1;
        #1;
        chk({tag, "_gnt"}, 32'(gnt), 32'(oh));
        step();
        req[r] = 1'b0;
        #1;
        chk({tag, "_busy_gnt"}, 32'(gnt), 32'h0);
        chk({tag, "_memwrite"}, 32'(mem_MemWrite), 32'(w & !exp_err));
        chk({tag, "_memread"},  32'(mem_MemRead),  32'(!w & !exp_err));
        if (!exp_err) chk({tag, "_memaddr"}, mem_Addr, a);
        if (w && !exp_err) chk({tag, "_memwdata"}, mem_Wdata, d);
        step();
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(oh));
        chk({tag, "_rsp_err"},   32'(rsp_err),   32'(exp_err));
        chk({tag, "_rsp_rdata"}, rsp_rdata, exp_rd);
        chk({tag, "_strobes_off"}, 32'({mem_MemWrite, mem_MemRead}), 32'h0);
        step();
        chk({tag, "_rsp_done"}, 32'(rsp_valid), 32'h0);
    endtask

    initial begin
        reset_n = 1'b0;
        req = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        #2;
        chk("rst_gnt",       32'(gnt),          32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid),    32'h0);
        chk("rst_rsp_err",   32'(rsp_err),      32'h0);
        chk("rst_rdata",     rsp_rdata,         32'h0);
        chk("rst_strobes",   32'({mem_MemWrite, mem_MemRead}), 32'h0);
        chk("rst_addr",      mem_Addr,          32'h0);
        step();
        reset_n = 1'b1;
        step();

        // Basic write then read-back, and clear word 4 for the reset test.
        txn(0, 1'b1, 32'h2008, 32'hDEADBEEF, 1'b0, 32'h0,        "wr2008");
        txn(0, 1'b0, 32'h2008, 32'h0,        1'b0, 32'hDEADBEEF, "rd2008");
        txn(0, 1'b1, 32'h2010, 32'h0,        1'b0, 32'h0,        "clr2010");

        // Address range and alignment.
        txn(0, 1'b1, 32'h2002, 32'h11111111, 1'b1, 32'h0,        "err_misalign");
        txn(0, 1'b0, 32'h1FFC, 32'h0,        1'b1, 32'h0,        "err_below");
        txn(0, 1'b1, 32'h27FC, 32'hA5A5A5A5, 1'b0, 32'h0,        "wr_last");
        txn(0, 1'b0, 32'h27FC, 32'h0,        1'b0, 32'hA5A5A5A5, "rd_last");
        txn(0, 1'b0, 32'h2800, 32'h0,        1'b1, 32'h0,        "err_above");

        // Preload word 5 and read it through requester 1.
        txn(0, 1'b1, 32'h2014, 32'h00000055, 1'b0, 32'h0,        "preload5");
        txn(1, 1'b0, 32'h2014, 32'h0,        1'b0, 32'h00000055, "dbg_rd5");

        // Continuous contention: RR alternates, fixed priority always picks 0.
        we = 2'b00; addr0 = 32'h2000; addr1 = 32'h2004;
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_gnt", 32'(gnt),    (i % 2 == 0) ? 32'h1 : 32'h2);
            chk("fp_gnt", 32'(fp_gnt), 32'h1);
            step();
            chk("rr_gap1", 32'(gnt), 32'h0);
            step();
            chk("rr_gap2", 32'(gnt), 32'h0);
            step();
        end
        req = 2'b00;
        #1;
        step();

        // Request 1 arriving mid-transaction waits until IDLE (T+3).
        we = 2'b01; addr0 = 32'h2018; wdata0 = 32'h00001111; addr1 = 32'h2014;
        req = 2'b01;
        #1;
        chk("busy_gnt_T", 32'(gnt), 32'h1);
        step();
        req = 2'b10;
        #1;
        chk("busy_gnt_T1", 32'(gnt), 32'h0);
        step();
        chk("busy_gnt_T2", 32'(gnt), 32'h0);
        chk("busy_rsp0",   32'(rsp_valid), 32'h1);
        step();
        chk("busy_gnt_T3", 32'(gnt), 32'h2);
        step();
        req = 2'b00;
        step();
        chk("busy_rsp1",   32'(rsp_valid), 32'h2);
        chk("busy_rdata1", rsp_rdata, 32'h00000055);
        step();

        // Reset during ACCESS of a write to word 4; pointer is at 1 beforehand.
        we = 2'b01; addr0 = 32'h2010; wdata0 = 32'h12345678;
        req = 2'b01;
        #1;
        chk("rstmid_gnt", 32'(gnt), 32'h1);
        step();
        chk("rstmid_access", 32'(mem_MemWrite), 32'h1);
        req = 2'b00;
        #1;
        reset_n = 1'b0;
        #1;
        chk("rstmid_strobe", 32'(mem_MemWrite), 32'h0);
        chk("rstmid_addr",   mem_Addr,          32'h0);
        chk("rstmid_wdata",  mem_Wdata,         32'h0);
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rstmid_no_rsp", 32'(rsp_valid), 32'h0);
        end
        we = 2'b00; addr0 = 32'h2010; addr1 = 32'h2004;
        req = 2'b11;
        #1;
        chk("rstmid_ptr_gnt", 32'(gnt), 32'h1);
        step();
        req = 2'b00;
        step();
        chk("rstmid_rd_valid", 32'(rsp_valid), 32'h1);
        chk("rstmid_rd_data",  rsp_rdata,      32'h0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
